// File: rtl/ovl_win_unchange_stim_gen_if.sv
// Purpose: bundles the request and observation signals of the
//          ovl_win_unchange stimulus generator.
// Macro:   OVL_STIM_GEN_LFSR_EN adds rand_mode (master -> slave).
// Signals (master drives the first group, slave drives the second):
//   enable, go, data[WIDTH], hold_cycles[CNT_W], inject, inj_off[CNT_W]
//   start_event, end_event, test_expr[WIDTH], busy, done, expect_fire,
//   win_count[CNT_W]
interface ovl_win_unchange_stim_gen_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             enable;
  logic             go;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] hold_cycles;
  logic             inject;
  logic [CNT_W-1:0] inj_off;
`ifdef OVL_STIM_GEN_LFSR_EN
  logic             rand_mode;
`endif
  logic             start_event;
  logic             end_event;
  logic [WIDTH-1:0] test_expr;
  logic             busy;
  logic             done;
  logic             expect_fire;
  logic [CNT_W-1:0] win_count;

  modport master (
`ifdef OVL_STIM_GEN_LFSR_EN
    output rand_mode,
`endif
    output enable, go, data, hold_cycles, inject, inj_off,
    input  start_event, end_event, test_expr, busy, done, expect_fire, win_count
  );

  modport slave (
`ifdef OVL_STIM_GEN_LFSR_EN
    input  rand_mode,
`endif
    input  enable, go, data, hold_cycles, inject, inj_off,
    output start_event, end_event, test_expr, busy, done, expect_fire, win_count
  );
endinterface

// File: rtl/ovl_win_unchange_stim_gen.sv
// Purpose: generates one ovl_win_unchange window per go request
//          (start pulse, hold phase, end pulse, idle gap) with test_expr
//          either stable or inverted from a chosen hold index onward.
// Macro:   OVL_STIM_GEN_LFSR_EN adds a 16-bit LFSR; rand_mode=1 at go
//          replaces data with LFSR[WIDTH-1:0].
// Ports:
//   clock_i  rising-edge clock
//   reset_i  synchronous active-high reset
//   bus      ovl_win_unchange_stim_gen_if.slave (request in, window out)
//
// state  | meaning
// -------+---------------------------------------------------
// IDLE   | waiting for go (busy=0)
// START  | start_event pulse, test_expr=data
// HOLD   | L hold cycles, optional inversion from inj_off on
// END    | end_event pulse, test_expr keeps its hold value
// GAP    | GAP_CYCLES cycles of test_expr=0
// DONE   | done pulse, expect_fire/win_count updated
module ovl_win_unchange_stim_gen #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  ovl_win_unchange_stim_gen_if.slave bus
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HOLD, S_END, S_GAP, S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] len_q, off_q, rem_q, idx_q;
  logic             inj_q;
  logic [GW-1:0]    gap_q;
  logic             start_q, end_q, busy_q, done_q, fire_q;
  logic [WIDTH-1:0] test_q;
  logic [CNT_W-1:0] count_q;

  logic [CNT_W-1:0] hold_len_d;
  logic [WIDTH-1:0] go_data_d;
  logic [CNT_W-1:0] idx_nxt_d;
  logic [WIDTH-1:0] hold0_val_d, hold_val_d;

`ifdef OVL_STIM_GEN_LFSR_EN
  logic [15:0] lfsr_q;

  // Fibonacci form, taps 16,14,13,11
  always_ff @(posedge clock_i) begin
    if (reset_i) lfsr_q <= 16'hACE1;
    else if (bus.enable)
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  always_comb begin
    hold_len_d = (bus.hold_cycles == '0) ? CNT_W'(1) : bus.hold_cycles;
`ifdef OVL_STIM_GEN_LFSR_EN
    go_data_d = bus.rand_mode ? lfsr_q[WIDTH-1:0] : bus.data;
`else
    go_data_d = bus.data;
`endif
    idx_nxt_d   = idx_q + CNT_W'(1);
    // inj_off >= L is never reached by the index, so no change happens
    hold0_val_d = (inj_q && off_q == '0)       ? ~data_q : data_q;
    hold_val_d  = (inj_q && idx_nxt_d >= off_q) ? ~data_q : data_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      len_q   <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      inj_q   <= 1'b0;
      gap_q   <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fire_q  <= 1'b0;
      test_q  <= '0;
      count_q <= '0;
    end else if (bus.enable) begin
      case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            state_q <= S_START;
            data_q  <= go_data_d;
            len_q   <= hold_len_d;
            inj_q   <= bus.inject;
            off_q   <= bus.inj_off;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            test_q  <= go_data_d;
          end
        end
        S_START: begin
          state_q <= S_HOLD;
          start_q <= 1'b0;
          idx_q   <= '0;
          rem_q   <= len_q - CNT_W'(1);
          test_q  <= hold0_val_d;
        end
        S_HOLD: begin
          if (rem_q == '0) begin
            state_q <= S_END;
            end_q   <= 1'b1;
          end else begin
            rem_q  <= rem_q - CNT_W'(1);
            idx_q  <= idx_nxt_d;
            test_q <= hold_val_d;
          end
        end
        S_END: begin
          end_q  <= 1'b0;
          test_q <= '0;
          if (GAP_CYCLES > 0) begin
            state_q <= S_GAP;
            gap_q   <= GW'(GAP_CYCLES - 1);
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            fire_q  <= inj_q && (off_q < len_q);
            count_q <= count_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            fire_q  <= inj_q && (off_q < len_q);
            count_q <= count_q + CNT_W'(1);
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.start_event = start_q;
  assign bus.end_event   = end_q;
  assign bus.test_expr   = test_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.expect_fire = fire_q;
  assign bus.win_count   = count_q;
endmodule

// File: tb/tb_ovl_win_unchange_stim_gen.sv
module tb_ovl_win_unchange_stim_gen;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int GAP   = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ovl_win_unchange_stim_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ovl_win_unchange_stim_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model state carried across windows
  int   m_count = 0;
  logic m_fire  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic s, input logic e, input logic b,
                           input logic d, input logic [WIDTH-1:0] te);
    check_val({tag, ".start"}, bus.start_event, s);
    check_val({tag, ".end"},   bus.end_event,   e);
    check_val({tag, ".busy"},  bus.busy,        b);
    check_val({tag, ".done"},  bus.done,        d);
    check_val({tag, ".texpr"}, bus.test_expr,   te);
    check_val({tag, ".fire"},  bus.expect_fire, m_fire);
    check_val({tag, ".count"}, bus.win_count,   m_count[CNT_W-1:0]);
  endtask

  // Window trace derived from offsets relative to the go sample cycle T:
  // n=1 start, n=2..1+L hold, n=2+L end, then GAP zeros, then done.
  task automatic check_at(input string tag, input int n, input int L, input logic [WIDTH-1:0] d,
                          input logic inj, input int off);
    int total;
    int k;
    logic [WIDTH-1:0] te;
    total = 3 + L + GAP;
    te = '0;
    if (n == 1) te = d;
    else if (n >= 2 && n <= 2 + L) begin
      k  = (n - 2 > L - 1) ? L - 1 : n - 2;
      te = (inj && k >= off) ? ~d : d;
    end
    check_all(tag, n == 1, n == 2 + L, (n >= 1 && n <= total), n == total, te);
  endtask

  task automatic run_window(input string tag, input logic [WIDTH-1:0] d, input int hold,
                            input logic inj, input int off, input int ign_at,
                            input int rst_at, input bit rand_en);
    int L;
    int total;
    int n;
    int guard;
    L     = (hold == 0) ? 1 : hold;
    total = 3 + L + GAP;
    n     = 0;
    guard = 0;
    @(negedge clock);
    bus.data        = d;
    bus.hold_cycles = CNT_W'(hold);
    bus.inject      = inj;
    bus.inj_off     = CNT_W'(off);
    bus.go          = 1'b1;
    bus.enable      = 1'b1;
    while (n < total + 1) begin
      logic was_en;
      @(posedge clock);
      was_en = bus.enable;
      @(negedge clock);
      if (was_en) begin
        n++;
        if (n == total) begin
          m_count = (m_count + 1) % (1 << CNT_W);
          m_fire  = inj && (off < L);
        end
      end
      bus.go   = 1'b0;
      bus.data = WIDTH'($urandom);
      check_at(tag, n, L, d, inj, off);
      guard++;
      if (guard > 400) begin
        check_val({tag, ".timeout"}, 32'(guard), 32'(total));
        break;
      end
      if (n == rst_at && was_en) begin
        bus.enable = 1'b1;
        reset      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        m_count = 0;
        m_fire  = 1'b0;
        check_all({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        return;
      end
      if (n < total) begin
        bus.enable = rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
        if (n == ign_at) bus.go = 1'b1;
      end else begin
        bus.enable = 1'b1;
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.enable      = 1'b1;
    bus.go          = 1'b1;
    bus.data        = 4'hF;
    bus.hold_cycles = 8'd2;
    bus.inject      = 1'b0;
    bus.inj_off     = '0;
`ifdef OVL_STIM_GEN_LFSR_EN
    bus.rand_mode   = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all("reset_go", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    reset  = 1'b0;
    bus.go = 1'b0;
    @(negedge clock);
    check_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    run_window("abort", 4'h5, 4, 1'b0, 0, -1, 3, 1'b0);
    @(negedge clock);
    check_all("after_abort", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    run_window("basic",    4'b0011, 4, 1'b0, 0, -1, -1, 1'b0);
    run_window("inject",   4'b1001, 3, 1'b1, 1, -1, -1, 1'b0);
    run_window("off_late", 4'b0110, 3, 1'b1, 5, -1, -1, 1'b0);
    run_window("hold0",    4'b1010, 0, 1'b0, 0,  2, -1, 1'b0);
    run_window("off_zero", 4'b1100, 2, 1'b1, 0, -1, -1, 1'b0);
    run_window("off_edge", 4'b0001, 3, 1'b1, 3, -1, -1, 1'b0);

    // enough windows to wrap win_count
    for (int i = 0; i < 260; i++) begin
      int h;
      int o;
      int ig;
      h  = $urandom_range(0, 8);
      o  = $urandom_range(0, 10);
      ig = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3 + h + GAP) : -1;
      run_window("rand", WIDTH'($urandom), h, 1'($urandom), o, ig, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
